// File: rtl/fb_spi_loader_if.sv
// fb_spi_loader_if
//   Bundles the SPI pins coming from the IO controller and the framebuffer
//   RAM write port driven by fb_spi_loader.
//   Ports (signals):
//     SPI_SCK, SPI_SS2, SPI_DI : SPI clock, active-low select, data (IO side drives)
//     ram_addr[ADDR_W-1:0]     : RAM write address
//     ram_data[15:0]           : RAM write data (8 pixels, pixel 0 in [1:0])
//     ram_wren                 : write strobe
//     busy, fill_done          : fill status
//   Modports: master = IO controller / RAM side, slave = fb_spi_loader.
//   Handshake: ram_wren is a valid-only strobe with no ready. The RAM takes a
//   word on every clk_ram cycle in which ram_wren is high, and ram_addr/ram_data
//   are only meaningful in those cycles (they hold their last value otherwise).
interface fb_spi_loader_if #(
  parameter int ADDR_W = 13
);
  logic              SPI_SCK;
  logic              SPI_SS2;
  logic              SPI_DI;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data;
  logic              ram_wren;
  logic              busy;
  logic              fill_done;

  modport master (
    output SPI_SCK, SPI_SS2, SPI_DI,
    input  ram_addr, ram_data, ram_wren, busy, fill_done
  );

  modport slave (
    input  SPI_SCK, SPI_SS2, SPI_DI,
    output ram_addr, ram_data, ram_wren, busy, fill_done
  );
endinterface

// File: rtl/fb_spi_loader.sv
// fb_spi_loader
//   Writer side of the 256x256 2bpp framebuffer. Receives an SPI byte stream,
//   assembles 16-bit pixel words and writes them to the RAM write port, all
//   on clk_ram. Address = {row[7:0], word_col[4:0]}.
//   Commands (first byte after SS falls):
//     0x01 addr_h addr_l {data_h data_l}*  : burst write, address auto-increments
//     0x02 pat_h pat_l                     : fill whole RAM with pattern
//                                            (only when FB_FILL_EN is defined)
//   Ports:
//     clk_ram   : RAM clock, the only clock
//     reset_n   : asynchronous active-low reset
//     bus       : fb_spi_loader_if.slave (SPI pins in, RAM write port + status out)
//     dbg_state : current FSM state encoding
//   Build option: define FB_FILL_EN to include the fill command; otherwise
//   busy and fill_done are tied low and 0x02 is an unknown command.
module fb_spi_loader #(
  parameter int ADDR_W   = 13,
  parameter int SYNC_LEN = 2
) (
  input  logic                    clk_ram,
  input  logic                    reset_n,
  fb_spi_loader_if.slave          bus,
  output logic [3:0]              dbg_state
);

  typedef logic [ADDR_W-1:0] addr_t;
  localparam addr_t ADDR_ONE = addr_t'(1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CMD    = 4'd1,
    S_ADDR_H = 4'd2,
    S_ADDR_L = 4'd3,
    S_DATA_H = 4'd4,
    S_DATA_L = 4'd5,
    S_PAT_H  = 4'd6,
    S_PAT_L  = 4'd7,
    S_FILL   = 4'd8,
    S_IGNORE = 4'd9
  } state_t;

  // ---------------- input synchronizers and edge detect ----------------
  // SS resets to the idle (high) level so reset release never fakes an SS edge.
  logic [SYNC_LEN-1:0] sck_s, ss_s, di_s;
  logic                sck_q, ss_q;
  logic                sck_sync, ss_sync, di_sync;
  logic                sck_rise, ss_rise, ss_fall;

  assign sck_sync = sck_s[SYNC_LEN-1];
  assign ss_sync  = ss_s[SYNC_LEN-1];
  assign di_sync  = di_s[SYNC_LEN-1];
  assign sck_rise = sck_sync & ~sck_q;
  assign ss_rise  = ss_sync & ~ss_q;
  assign ss_fall  = ~ss_sync & ss_q;

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      sck_s <= '0;
      ss_s  <= '1;
      di_s  <= '0;
      sck_q <= 1'b0;
      ss_q  <= 1'b1;
    end else begin
      sck_s <= {sck_s[SYNC_LEN-2:0], bus.SPI_SCK};
      ss_s  <= {ss_s[SYNC_LEN-2:0], bus.SPI_SS2};
      di_s  <= {di_s[SYNC_LEN-2:0], bus.SPI_DI};
      sck_q <= sck_sync;
      ss_q  <= ss_sync;
    end
  end

  // ---------------- byte assembler ----------------
  // byte_vld is a registered one-cycle pulse; the FSM consumes it the
  // following cycle, which gives the fixed SYNC_LEN+2 pin-to-strobe latency.
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] byte_q;
  logic       byte_vld;

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= 3'd0;
      shreg    <= '0;
      byte_q   <= '0;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      if (ss_rise) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise && !ss_sync) begin
        shreg   <= {shreg[5:0], di_sync};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_q   <= {shreg, di_sync};
          byte_vld <= 1'b1;
        end
      end
    end
  end

  // ---------------- command FSM and write port ----------------
  state_t      state;
  logic [7:0]  hi_q;
  addr_t       addr;
  addr_t       addr_q;
  logic [15:0] data_q;
  logic        wren_q;
`ifdef FB_FILL_EN
  logic [15:0] pat_q;
  logic        busy_q;
  logic        done_q;
`endif

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      hi_q   <= '0;
      addr   <= '0;
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
`ifdef FB_FILL_EN
      pat_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`endif
    end else begin
      wren_q <= 1'b0;
`ifdef FB_FILL_EN
      busy_q <= 1'b0;
      done_q <= 1'b0;
      // A running fill ignores all SPI activity, including SS edges.
      if (state == S_FILL) begin
        wren_q <= 1'b1;
        addr_q <= addr;
        data_q <= pat_q;
        busy_q <= 1'b1;
        addr   <= addr + ADDR_ONE;
        if (&addr) begin
          done_q <= 1'b1;
          // An SS rise during the fill was swallowed, so look at the level.
          state  <= ss_sync ? S_IDLE : S_IGNORE;
        end
      end else
`endif
      if (ss_rise) begin
        state <= S_IDLE;
      end else if (state == S_IDLE) begin
        if (ss_fall) state <= S_CMD;
      end else if (byte_vld) begin
        case (state)
          S_CMD: begin
            if (byte_q == 8'h01) state <= S_ADDR_H;
`ifdef FB_FILL_EN
            else if (byte_q == 8'h02) state <= S_PAT_H;
`endif
            else state <= S_IGNORE;
          end
          S_ADDR_H: begin
            hi_q  <= byte_q;
            state <= S_ADDR_L;
          end
          S_ADDR_L: begin
            addr  <= addr_t'({hi_q, byte_q});
            state <= S_DATA_H;
          end
          S_DATA_H: begin
            hi_q  <= byte_q;
            state <= S_DATA_L;
          end
          S_DATA_L: begin
            wren_q <= 1'b1;
            addr_q <= addr;
            data_q <= {hi_q, byte_q};
            addr   <= addr + ADDR_ONE;
            state  <= S_DATA_H;
          end
`ifdef FB_FILL_EN
          S_PAT_H: begin
            hi_q  <= byte_q;
            state <= S_PAT_L;
          end
          S_PAT_L: begin
            pat_q  <= {hi_q, byte_q};
            addr   <= '0;
            busy_q <= 1'b1;
            state  <= S_FILL;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.ram_addr = addr_q;
  assign bus.ram_data = data_q;
  assign bus.ram_wren = wren_q;
`ifdef FB_FILL_EN
  assign bus.busy      = busy_q;
  assign bus.fill_done = done_q;
`else
  assign bus.busy      = 1'b0;
  assign bus.fill_done = 1'b0;
`endif
  assign dbg_state = state;

endmodule

// File: tb/tb_fb_spi_loader.sv
// tb_fb_spi_loader
//   Bench for fb_spi_loader. SPI bytes are driven bit by bit; every expected
//   RAM write is pushed as {addr,data} into exp_q before its bytes are sent
//   and popped by a negedge monitor whenever ram_wren is seen.
//   Fill scenarios are built only when FB_FILL_EN is defined.
module tb_fb_spi_loader;
  localparam int ADDR_W     = 13;
  localparam int SYNC_LEN   = 2;
  localparam int EW         = ADDR_W + 16;
  localparam int FILL_WORDS = 1 << ADDR_W;

  logic             clk_ram = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       dbg_state;
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    mon_exp;
  logic [ADDR_W-1:0] addr_max;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  int wr_cyc = 0;
  int done_pulses = 0;
  int busy_cycles = 0;

  // fill watcher results
  int               w_gaps, w_dones;
  logic             w_started, w_busy_at_start, w_post_busy, w_post_wren;
  logic [ADDR_W-1:0] w_done_addr;

  fb_spi_loader_if #(.ADDR_W(ADDR_W)) bus ();

  fb_spi_loader #(.ADDR_W(ADDR_W), .SYNC_LEN(SYNC_LEN)) dut (
    .clk_ram   (clk_ram),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_ram = ~clk_ram;
  always @(posedge clk_ram) cyc <= cyc + 1;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_ram) begin
    if (reset_n && bus.ram_wren === 1'b1) begin
      wr_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got addr=%h data=%h expected no write", bus.ram_addr, bus.ram_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.ram_addr, bus.ram_data} !== mon_exp) begin
          errors++;
          $display("FAIL wr_data got addr=%h data=%h expected addr=%h data=%h",
                   bus.ram_addr, bus.ram_data, mon_exp[EW-1:16], mon_exp[15:0]);
        end
      end
    end
    if (reset_n && bus.fill_done === 1'b1) done_pulses++;
    if (reset_n && bus.busy === 1'b1) busy_cycles++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      @(posedge clk_ram); #1;
      bus.SPI_SCK = 1'b0;
      bus.SPI_DI  = b[i];
      repeat (8) @(posedge clk_ram);
      #1;
      bus.SPI_SCK = 1'b1;
      last_rise   = cyc;
      repeat (7) @(posedge clk_ram);
    end
  endtask

  task automatic ss_start();
    @(posedge clk_ram); #1;
    bus.SPI_SS2 = 1'b0;
    repeat (8) @(posedge clk_ram);
  endtask

  task automatic ss_end();
    repeat (8) @(posedge clk_ram);
    #1 bus.SPI_SCK = 1'b0;
    repeat (8) @(posedge clk_ram);
    #1 bus.SPI_SS2 = 1'b1;
    repeat (16) @(posedge clk_ram);
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drain_check(input string name);
    repeat (40) @(negedge clk_ram);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes got %0d pending expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic watch_fill();
    w_gaps = 0; w_dones = 0; w_started = 1'b0; w_busy_at_start = 1'b0;
    w_post_busy = 1'b1; w_post_wren = 1'b1; w_done_addr = '0;
    for (int k = 0; k < 400 && bus.ram_wren !== 1'b1; k++) @(negedge clk_ram);
    if (bus.ram_wren === 1'b1) begin
      w_started = 1'b1;
      w_busy_at_start = bus.busy;
      for (int i = 0; i < FILL_WORDS; i++) begin
        if (i > 0) @(negedge clk_ram);
        if (bus.ram_wren !== 1'b1) w_gaps++;
        if (bus.fill_done === 1'b1) begin
          w_dones++;
          w_done_addr = bus.ram_addr;
        end
      end
      @(negedge clk_ram);
      w_post_busy = bus.busy;
      w_post_wren = bus.ram_wren;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_ram);
    @(negedge clk_ram);
    checks++;
    if ({bus.ram_wren, bus.busy, bus.fill_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes got %b expected 000", {bus.ram_wren, bus.busy, bus.fill_done});
    end
    checks++;
    if ({bus.ram_addr, bus.ram_data} !== '0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h data=%h expected 0", bus.ram_addr, bus.ram_data);
    end
    checks++;
    if (dbg_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got %0d expected 0", dbg_state);
    end
    @(posedge clk_ram); #1 reset_n = 1'b1;
    repeat (4) @(posedge clk_ram);
  endtask

  task automatic test_single_write();
    push_wr(13'h0020, 16'hABCD);
    push_wr(13'h0021, 16'h1234);
    ss_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'hAB); send_byte(8'hCD);
    checks++;
    if (wr_cyc - last_rise !== SYNC_LEN + 2) begin
      errors++;
      $display("FAIL latency got %0d expected %0d", wr_cyc - last_rise, SYNC_LEN + 2);
    end
    send_byte(8'h12); send_byte(8'h34);
    ss_end();
    drain_check("single_write");
    @(negedge clk_ram);
    checks++;
    if ({bus.ram_wren, bus.ram_addr, bus.ram_data} !== {1'b0, 13'h0021, 16'h1234}) begin
      errors++;
      $display("FAIL hold got wren=%b addr=%h data=%h expected 0 0021 1234",
               bus.ram_wren, bus.ram_addr, bus.ram_data);
    end
  endtask

  task automatic test_wrap();
    push_wr(13'h1FFF, 16'h1111);
    push_wr(13'h0000, 16'h2222);
    ss_start();
    send_byte(8'h01); send_byte(8'h1F); send_byte(8'hFF);
    send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
    ss_end();
    drain_check("wrap");
  endtask

  task automatic test_abort();
    ss_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'hAB);
    ss_end();
    push_wr(13'h0010, 16'h1122);
    ss_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h11); send_byte(8'h22);
    ss_end();
    drain_check("abort");
  endtask

  task automatic test_unknown_cmd();
    ss_start();
    send_byte(8'h7E); send_byte(8'h00); send_byte(8'h10); send_byte(8'h55); send_byte(8'h66);
    ss_end();
    drain_check("unknown_cmd");
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] d;
    a = 16'($urandom_range(0, FILL_WORDS - 1));
    ss_start();
    send_byte(8'h01); send_byte(a[15:8]); send_byte(a[7:0]);
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom_range(0, 16'hFFFF));
      push_wr(ADDR_W'(a + 16'(i)), d);
      send_byte(d[15:8]); send_byte(d[7:0]);
    end
    ss_end();
    drain_check("back_to_back");
  endtask

  task automatic test_reset_mid_write();
    push_wr(13'h0040, 16'h1122);
    ss_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h40); send_byte(8'h11);
    fork
      send_byte(8'h22);
      begin
        for (int k = 0; k < 400 && bus.ram_wren !== 1'b1; k++) @(negedge clk_ram);
        checks++;
        if (bus.ram_wren !== 1'b1) begin
          errors++;
          $display("FAIL rst_write_timeout got wren=%b expected 1", bus.ram_wren);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.ram_wren, bus.busy, bus.fill_done, bus.ram_addr, bus.ram_data} !== '0) begin
          errors++;
          $display("FAIL rst_write_outputs got wren=%b addr=%h data=%h expected 0",
                   bus.ram_wren, bus.ram_addr, bus.ram_data);
        end
      end
    join
    exp_q.delete();
    send_byte(8'h33); send_byte(8'h44);
    ss_end();
    @(posedge clk_ram); #1 reset_n = 1'b1;
    drain_check("rst_write");
  endtask

`ifdef FB_FILL_EN
  task automatic test_fill_ss_low();
    for (int i = 0; i < FILL_WORDS; i++) push_wr(ADDR_W'(i), 16'hF00F);
    done_pulses = 0;
    ss_start();
    send_byte(8'h02); send_byte(8'hF0);
    fork
      begin send_byte(8'h0F); send_byte(8'h01); send_byte(8'h00); end
      watch_fill();
    join
    checks++;
    if ({w_started, w_busy_at_start} !== 2'b11) begin
      errors++;
      $display("FAIL fill_start got started=%b busy=%b expected 1 1", w_started, w_busy_at_start);
    end
    checks++;
    if (w_gaps !== 0) begin
      errors++;
      $display("FAIL fill_contiguous got %0d gaps expected 0", w_gaps);
    end
    checks++;
    if (w_dones !== 1 || w_done_addr !== addr_max) begin
      errors++;
      $display("FAIL fill_done got pulses=%0d addr=%h expected 1 %h", w_dones, w_done_addr, addr_max);
    end
    checks++;
    if ({w_post_busy, w_post_wren} !== 2'b00) begin
      errors++;
      $display("FAIL fill_end got busy=%b wren=%b expected 0 0", w_post_busy, w_post_wren);
    end
    // SS still low: remaining bytes fall into IGNORE and write nothing.
    send_byte(8'h12); send_byte(8'h34);
    ss_end();
    drain_check("fill_ss_low");
    checks++;
    if (done_pulses !== 1) begin
      errors++;
      $display("FAIL fill_done_count got %0d expected 1", done_pulses);
    end
  endtask

  task automatic test_fill_during_spi();
    for (int i = 0; i < FILL_WORDS; i++) push_wr(ADDR_W'(i), 16'hC33C);
    ss_start();
    send_byte(8'h02); send_byte(8'hC3);
    fork
      begin
        send_byte(8'h3C);
        ss_end();
        ss_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB);
        ss_end();
      end
      watch_fill();
    join
    checks++;
    if (w_started !== 1'b1 || w_gaps !== 0) begin
      errors++;
      $display("FAIL fill_spi_contiguous got started=%b gaps=%0d expected 1 0", w_started, w_gaps);
    end
    checks++;
    if (w_dones !== 1 || w_post_busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_spi_end got pulses=%0d busy=%b expected 1 0", w_dones, w_post_busy);
    end
    drain_check("fill_spi");
    // The loader is back in IDLE and takes a normal transaction.
    push_wr(13'h0005, 16'hAABB);
    ss_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB);
    ss_end();
    drain_check("after_fill");
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < FILL_WORDS; i++) push_wr(ADDR_W'(i), 16'h1234);
    ss_start();
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    repeat (100) @(posedge clk_ram);
    #3;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_fill_running got busy=%b expected 1", bus.busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.ram_wren, bus.busy, bus.fill_done, bus.ram_addr, bus.ram_data} !== '0 || dbg_state !== 4'd0) begin
      errors++;
      $display("FAIL rst_fill_outputs got wren=%b busy=%b done=%b addr=%h data=%h state=%0d expected all 0",
               bus.ram_wren, bus.busy, bus.fill_done, bus.ram_addr, bus.ram_data, dbg_state);
    end
    exp_q.delete();
    ss_end();
    @(posedge clk_ram); #1 reset_n = 1'b1;
    busy_cycles = 0;
    repeat (300) @(negedge clk_ram);
    checks++;
    if (busy_cycles !== 0) begin
      errors++;
      $display("FAIL rst_fill_resumed got busy_cycles=%0d expected 0", busy_cycles);
    end
    drain_check("rst_fill");
  endtask
`else
  task automatic test_fill_disabled();
    busy_cycles = 0;
    done_pulses = 0;
    ss_start();
    send_byte(8'h02); send_byte(8'hF0); send_byte(8'h0F); send_byte(8'hAB); send_byte(8'hCD);
    ss_end();
    drain_check("fill_disabled");
    checks++;
    if (busy_cycles !== 0 || done_pulses !== 0) begin
      errors++;
      $display("FAIL fill_disabled_status got busy=%0d done=%0d expected 0 0", busy_cycles, done_pulses);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus.SPI_SCK = 1'b0;
    bus.SPI_SS2 = 1'b1;
    bus.SPI_DI  = 1'b0;
    addr_max    = '1;
    test_reset();
    test_single_write();
    test_wrap();
    test_abort();
    test_unknown_cmd();
    test_back_to_back();
    test_reset_mid_write();
`ifdef FB_FILL_EN
    test_fill_ss_low();
    test_fill_during_spi();
    test_reset_mid_fill();
`else
    test_fill_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    errors++;
    $display("FAIL global_timeout got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
